// File: rtl/mem_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_stage_pkg                                                   |
// | Purpose  : Shared types and widths for the memory-access pipeline stage.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package mem_stage_pkg;

    localparam int DATA_W    = 16;
    localparam int REG_IDX_W = 3;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic                 valid;
        logic [DATA_W-1:0]    alu;
        logic [DATA_W-1:0]    store;
        logic [REG_IDX_W-1:0] rd;
        logic                 regwrite;
        logic                 memread;
        logic                 memwrite;
        logic                 out;
    } exmem_t;

endpackage
`default_nettype wire

// File: rtl/flag_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : flag_reg                                                        |
// | Purpose  : Architectural SZCV flag register with synchronous reset and     |
// |            load enable.                                                    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module flag_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [3:0] i_szcv,
    output logic [3:0] o_szcv
);

    logic [3:0] r_szcv;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_szcv <= 4'b0000;
        end else if (i_load) begin
            r_szcv <= i_szcv;
        end
    end

    assign o_szcv = r_szcv;

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_stage                                                       |
// | Purpose  : Memory-access stage: EX/MEM register, flag register, load/store |
// |            req/ack sequencing with pipe stall, MEM/WB register and both    |
// |            forwarding sources. Optional OUT port: MEM_STAGE_OUT_PORT_EN.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_ex,
    input  logic [DATA_W-1:0]    ALUres_ex,
    input  logic [DATA_W-1:0]    rd2_ex2,
    input  logic                 S_ex,
    input  logic                 Z_ex,
    input  logic                 C_ex,
    input  logic                 V_ex,
    input  logic                 flagwrite_ex,
    input  logic                 memread_ex,
    input  logic                 memwrite_ex,
    input  logic                 regwrite_ex,
    input  logic                 out_ex,
    input  logic [REG_IDX_W-1:0] rd_ex,
    input  logic                 flush_ex,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [DATA_W-1:0]    dmem_addr,
    output logic [DATA_W-1:0]    dmem_wdata,
    input  logic                 dmem_ack,
    input  logic [DATA_W-1:0]    dmem_rdata,
    output logic                 stall_mem,
    output logic [DATA_W-1:0]    regwrite_dat_mem,
    output logic [REG_IDX_W-1:0] rd_mem,
    output logic                 regwrite_mem,
    output logic                 memread_mem,
    output logic [DATA_W-1:0]    regwrite_dat,
    output logic [REG_IDX_W-1:0] rd_wb,
    output logic                 regwrite_wb,
    output logic                 S,
    output logic                 Z,
    output logic                 C,
    output logic                 V,
    output logic [DATA_W-1:0]    out_dat,
    output logic                 out_valid
);

    exmem_t                r_m;
    mem_state_t            r_state;
    logic                  r_wb_regwrite;
    logic [DATA_W-1:0]     r_wb_dat;
    logic [REG_IDX_W-1:0]  r_wb_rd;

    logic                  w_access;
    logic                  w_stall;
    logic                  w_capture;
    logic                  w_ex_live;
    logic                  w_ex_memop;
    logic                  w_flag_load;
    logic                  w_out_field;
    logic [3:0]            w_szcv;

    assign w_access    = (r_state == ACCESS);
    // Combinational on ack so the ack cycle itself releases the pipe.
    assign w_stall     = w_access & ~dmem_ack;
    assign w_capture   = ~w_stall;
    assign w_ex_live   = valid_ex & ~flush_ex;
    assign w_ex_memop  = w_ex_live & (memread_ex | memwrite_ex);
    assign w_flag_load = w_capture & w_ex_live & flagwrite_ex;

`ifdef MEM_STAGE_OUT_PORT_EN
    assign w_out_field = out_ex;
`else
    assign w_out_field = 1'b0;
`endif

    // EX/MEM register; stores never write the register file.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_m <= '0;
        end else if (w_capture) begin
            r_m.valid    <= w_ex_live;
            r_m.alu      <= ALUres_ex;
            r_m.store    <= rd2_ex2;
            r_m.rd       <= rd_ex;
            r_m.regwrite <= regwrite_ex & ~memwrite_ex;
            r_m.memread  <= memread_ex;
            r_m.memwrite <= memwrite_ex;
            r_m.out      <= w_out_field;
        end
    end

    // Next state follows the instruction entering EX/MEM on the same edge,
    // which lets back-to-back memory ops keep the FSM in ACCESS.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
        end else if (w_capture) begin
            r_state <= w_ex_memop ? ACCESS : RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wb_regwrite <= 1'b0;
            r_wb_dat      <= '0;
            r_wb_rd       <= '0;
        end else begin
            r_wb_regwrite <= r_m.valid & r_m.regwrite & w_capture;
            r_wb_dat      <= r_m.memread ? dmem_rdata : r_m.alu;
            r_wb_rd       <= r_m.rd;
        end
    end

    flag_reg u_flag_reg (
        .clk    (clk),
        .rst    (reset),
        .i_load (w_flag_load),
        .i_szcv ({S_ex, Z_ex, C_ex, V_ex}),
        .o_szcv (w_szcv)
    );

    assign {S, Z, C, V} = w_szcv;

    assign dmem_req   = w_access;
    assign dmem_we    = w_access & r_m.memwrite;
    assign dmem_addr  = r_m.alu;
    assign dmem_wdata = r_m.store;
    assign stall_mem  = w_stall;

    // A load's EX/MEM alu field is its address, never forwardable data.
    assign regwrite_dat_mem = r_m.alu;
    assign rd_mem           = r_m.rd;
    assign regwrite_mem     = r_m.valid & r_m.regwrite & ~r_m.memread;
    assign memread_mem      = r_m.valid & r_m.memread;

    assign regwrite_dat = r_wb_dat;
    assign rd_wb        = r_wb_rd;
    assign regwrite_wb  = r_wb_regwrite;

`ifdef MEM_STAGE_OUT_PORT_EN
    logic                  r_out_valid;
    logic [DATA_W-1:0]     r_out_dat;
    logic                  w_out_fire;

    assign w_out_fire = r_m.valid & r_m.out & w_capture;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_dat   <= '0;
        end else begin
            r_out_valid <= w_out_fire;
            if (w_out_fire) begin
                r_out_dat <= r_m.store;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_dat   = r_out_dat;
`else
    logic w_unused_out;

    assign w_unused_out = out_ex ^ r_m.out;
    assign out_valid    = 1'b0;
    assign out_dat      = '0;
`endif

endmodule
`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 16-bit pipelined core, directly downstream of the execute stage. Captures the execute results (ALU result, forwarded store data, SZCV flags, control bits) into the EX/MEM register and owns the architectural flag register. Runs load/store against data memory over a req/ack handshake, stalling the pipe while an access is outstanding. Produces the MEM/WB register and both forwarding sources (`regwrite_dat_mem`, `regwrite_dat`) consumed by execute.

## Interface
- No parameters; datapath fixed at 16 bits, register index 3 bits.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `valid_ex` in 1: the execute stage holds a real instruction.
- `ALUres_ex` in 16: ALU result, also the memory address.
- `rd2_ex2` in 16: forwarded store data.
- `S_ex`, `Z_ex`, `C_ex`, `V_ex` in 1 each: ALU flags.
- `flagwrite_ex`, `memread_ex`, `memwrite_ex`, `regwrite_ex`, `out_ex` in 1 each: control bits.
- `rd_ex` in 3: destination register.
- `flush_ex` in 1: squash the instruction in execute (taken branch).
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out 16, `dmem_wdata` out 16: memory request.
- `dmem_ack` in 1, `dmem_rdata` in 16: memory response; read data is valid with `ack`.
- `stall_mem` out 1: freeze all upstream stages.
- `regwrite_dat_mem` out 16, `rd_mem` out 3, `regwrite_mem` out 1, `memread_mem` out 1: EX/MEM forwarding and hazard view.
- `regwrite_dat` out 16, `rd_wb` out 3, `regwrite_wb` out 1: MEM/WB register (write-back and forwarding).
- `S`, `Z`, `C`, `V` out 1 each: flag register.
- `out_dat` out 16, `out_valid` out 1: OUT port (macro only).

## Operation
- EX/MEM capture when `!stall_mem`:
  - `m_valid <= valid_ex & !flush_ex`.
  - All other fields always load.
- Flags:
  - SZCV loads `*_ex` on capture when `valid_ex & !flush_ex & flagwrite_ex`.
  - Otherwise SZCV holds.
- FSM, two states:
  - RUN: no access outstanding. Go to ACCESS when the captured instruction has `m_valid & (memread|memwrite)`.
  - ACCESS: `dmem_req = 1`; `dmem_we = memwrite`; `dmem_addr = m_alu`; `dmem_wdata = m_store`.
  - ACCESS → RUN on the cycle `dmem_ack` is sampled high. If the next instruction captured on that same edge is also a memory op, the FSM stays in ACCESS and the new request starts next cycle.
- `stall_mem = (state==ACCESS) & !dmem_ack`. This is combinational, so the ack cycle itself releases the pipe.
- MEM/WB update every cycle:
  - `wb_valid = m_valid & !stall_mem`.
  - `regwrite_wb = wb_valid & m_regwrite`.
  - `regwrite_dat` = `dmem_rdata` for loads, otherwise `m_alu`.
  - `rd_wb = m_rd`.
- While stalled, MEM/WB receives a bubble (`regwrite_wb = 0`).
- Forwarding view:
  - `regwrite_dat_mem = m_alu`.
  - `regwrite_mem = m_valid & m_regwrite & !m_memread`, so a load never forwards its address.
  - `memread_mem = m_valid & m_memread`, for load-use stall detection upstream.
- A store with `regwrite` set is treated as a control error; `regwrite` is ignored for stores.

## Timing
- Reset values: state RUN, `m_valid` 0, `regwrite_wb` 0, SZCV 0, `dmem_req` 0, `out_valid` 0. All data registers 0.
- Reset mid-access: `dmem_req` drops on the next cycle; any late `ack` is ignored in RUN.
- Non-memory instruction: EX/MEM at edge N, MEM/WB at N+1, no stall.
- Memory op with `ack` k cycles after `req` rises (k ≥ 0; `ack` may arrive in the first ACCESS cycle): `stall_mem` is high for exactly k cycles.
- `dmem_req` stays high, and address/data stay stable, until `ack`.
- `flush_ex` during stall: ignored, because upstream is frozen. The control unit holds `flush_ex` until the stall clears.
- `flagwrite` on a squashed or invalid instruction never changes SZCV.

## Configuration
- `MEM_STAGE_OUT_PORT_EN` defined:
  - When `m_valid & m_out & !stall_mem`, `out_dat <= m_store` and `out_valid <= 1` for one cycle.
  - Otherwise `out_valid <= 0`; `out_dat` holds.
- Undefined: `out_dat` = 0, `out_valid` = 0, no registers inferred; `out_ex` is ignored.

## Structure
- Shared package:
  - `mem_state_t` enum {RUN, ACCESS}.
  - Packed struct `exmem_t` (valid, alu, store, rd, regwrite, memread, memwrite, out).
  - Constants `DATA_W = 16`, `REG_IDX_W = 3`.
- One sub-module, `flag_reg`: SZCV register with synchronous reset and load enable.

## Test plan
- ADD, `ALUres_ex = 16'h1234`, `rd_ex = 3`, regwrite → `regwrite_dat_mem = 1234` next cycle; `regwrite_dat = 1234`, `rd_wb = 3` the cycle after; no stall.
- Load at `0x0040`, `ack` after 3 cycles with `rdata = 16'hBEEF` → `stall_mem` high for 3 cycles; `regwrite_dat = BEEF`, `regwrite_wb = 1` on the cycle after `ack`.
- Store `0xA5A5` to `0x0010`, `ack` in the same cycle `req` rises → zero stall; `dmem_we = 1`; `regwrite_wb` stays 0.
- Back-to-back loads, each acked after 1 cycle → FSM stays ACCESS across the boundary; two separate `req` phases; 1 stall cycle each.
- `flagwrite` with `Z_ex = 1` and `flush_ex = 1` → Z stays 0; repeated without flush → Z = 1.
- `reset` asserted during a pending access → `dmem_req = 0` next cycle; all outputs at reset values; later `ack` has no effect.
